// File: rtl/adder_sixteen_bit_pkg.sv
// Shared sizing constants for the registered ripple-carry adder.
package adder_sixteen_bit_pkg;

  // Default operand/sum width used in the 8x8 multiplier datapath.
  localparam int ADDER_WIDTH = 16;

  // Bits per ripple slice; the slice module is hard-wired to this size.
  localparam int SLICE = 4;

  // Number of 4-bit slices needed to cover a given operand width.
  function automatic int num_slices(input int width);
    return width / SLICE;
  endfunction

endpackage : adder_sixteen_bit_pkg

// File: rtl/adder_sixteen_bit_if.sv
// Operand/result bundle for the registered adder.
//
// Handshake: in_valid qualifies dataa/datab for the single cycle in which it
// is high; there is no ready/backpressure, so every cycle with in_valid=1 at
// a rising edge (and reset=0) is accepted. out_valid pulses for exactly one
// cycle on the following edge, and sum/cout are valid while it is high.
interface adder_sixteen_bit_if
  import adder_sixteen_bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  // Producer of operands, consumer of results.
  modport master (
    output in_valid, dataa, datab,
    input  sum, cout, out_valid
  );

  // The adder itself.
  modport slave (
    input  in_valid, dataa, datab,
    output sum, cout, out_valid
  );

endinterface : adder_sixteen_bit_if

// File: rtl/adder_sixteen_bit_four_bit.sv
// Combinational 4-bit ripple-carry adder slice.
module adder_four_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co
);

  // Internal carries kept as separate nets so the ripple stays a clean chain.
  logic c1;
  logic c2;
  logic c3;

  // Bit 0
  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1   = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);

  // Bit 1
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign c2   = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);

  // Bit 2
  assign s[2] = a[2] ^ b[2] ^ c2;
  assign c3   = (a[2] & b[2]) | (a[2] & c2) | (b[2] & c2);

  // Bit 3 and slice carry-out
  assign s[3] = a[3] ^ b[3] ^ c3;
  assign co   = (a[3] & b[3]) | (a[3] & c3) | (b[3] & c3);

endmodule : adder_four_bit

// File: rtl/adder_sixteen_bit.sv
// Registered unsigned adder: ripple chain of 4-bit slices feeding
// sum/cout/out_valid registers with one cycle of latency.
module adder_sixteen_bit
  import adder_sixteen_bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  adder_sixteen_bit_if.slave   bus
);

  localparam int NSLICE = num_slices(WIDTH);

  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_q;
  logic             cout_d;
  logic             valid_q;
  logic             valid_d;

  // Ripple chain: each slice owns its carry nets; slice 0 has no carry-in.
  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    logic ci;
    logic co;

    if (k == 0) begin : g_lsb
      assign ci = 1'b0;
    end else begin : g_upper
      assign ci = g_slice[k-1].co;
    end

    adder_four_bit u_slice (
      .a   (bus.dataa[SLICE*k +: SLICE]),
      .b   (bus.datab[SLICE*k +: SLICE]),
      .cin (ci),
      .s   (sum_c[SLICE*k +: SLICE]),
      .co  (co)
    );
  end : g_slice

  // The last slice's carry is bit WIDTH of the full-precision sum.
  assign cout_c = g_slice[NSLICE-1].co;

  // Next-state: capture on in_valid, otherwise hold result and drop valid.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d   = sum_c;
      cout_d  = cout_c;
      valid_d = 1'b1;
    end
  end

  // Output registers; reset wins over a same-cycle operand, discarding it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = valid_q;

endmodule : adder_sixteen_bit

// File: tb/tb_adder_sixteen_bit.sv
// Bench for the registered 16-bit adder: directed vector table, a
// between-edges sequence, and a randomized sweep against a reference model.
module tb_adder_sixteen_bit;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_sixteen_bit_if #(.WIDTH(W)) bus ();

  adder_sixteen_bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_tests;
  int n_failed;

  // Expected {out_valid, cout, sum} per checked cycle.
  logic [W+1:0] exp_q[$];

  typedef struct {
    string      name;
    logic       rst;
    logic       vld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+1:0] exp;   // {out_valid, cout, sum} after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic rst, input logic vld,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ov, input logic co, input logic [W-1:0] s);
    vec_t v;
    v.name = name;
    v.rst  = rst;
    v.vld  = vld;
    v.a    = a;
    v.b    = b;
    v.exp  = {ov, co, s};
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic vld,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    reset        = rst;
    bus.in_valid = vld;
    bus.dataa    = a;
    bus.datab    = b;
  endtask

  // Advance one edge and sample #1 later, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W+1:0] exp);
    logic [W+1:0] act;
    act = {bus.out_valid, bus.cout, bus.sum};
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got {ov,cout,sum}=%0h_%0h_%04h expected %0h_%0h_%04h",
               name, act[W+1], act[W], act[W-1:0], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ov;

  // Model of one rising edge using plain integer arithmetic.
  task automatic model_edge(input logic rst, input logic vld,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned total;
    if (rst) begin
      m_sum  = '0;
      m_cout = 1'b0;
      m_ov   = 1'b0;
    end else if (vld) begin
      total  = int'(a) + int'(b);
      m_sum  = W'(total % 65536);
      m_cout = (total >= 65536);
      m_ov   = 1'b1;
    end else begin
      m_ov   = 1'b0;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    n_tests  = 0;
    n_failed = 0;
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0001);

    // Directed table: each row is applied for one edge, then checked.
    vecs.push_back(mk("reset_c0",     1, 1, 16'hFFFF, 16'h0001, 0, 0, 16'h0000));
    vecs.push_back(mk("reset_c1",     1, 1, 16'hFFFF, 16'h0001, 0, 0, 16'h0000));
    vecs.push_back(mk("small_10p6",   0, 1, 16'd10,   16'd6,    1, 0, 16'd16));
    vecs.push_back(mk("b2b_2p4",      0, 1, 16'd2,    16'd4,    1, 0, 16'd6));
    vecs.push_back(mk("b2b_500p256",  0, 1, 16'd500,  16'd256,  1, 0, 16'd756));
    vecs.push_back(mk("ovf_ffff_p1",  0, 1, 16'hFFFF, 16'h0001, 1, 1, 16'h0000));
    vecs.push_back(mk("ovf_8000x2",   0, 1, 16'h8000, 16'h8000, 1, 1, 16'h0000));
    vecs.push_back(mk("idle_hold",    0, 0, 16'h1234, 16'h4321, 0, 1, 16'h0000));
    vecs.push_back(mk("chain_0fff",   0, 1, 16'h0FFF, 16'h0001, 1, 0, 16'h1000));
    vecs.push_back(mk("idle_hold2",   0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 16'h1000));
    vecs.push_back(mk("max_ffff_x2",  0, 1, 16'hFFFF, 16'hFFFF, 1, 1, 16'hFFFE));
    vecs.push_back(mk("rst_mid_op",   1, 1, 16'h1234, 16'h1111, 0, 0, 16'h0000));
    vecs.push_back(mk("no_pulse",     0, 0, 16'h1234, 16'h1111, 0, 0, 16'h0000));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].a, vecs[i].b);
      tick();
      check(vecs[i].name, vecs[i].exp);
    end

    // Inputs moving between edges must not reach the outputs.
    drive(1'b0, 1'b1, 16'h0003, 16'h0004);
    tick();
    check("mid_capture", {1'b1, 1'b0, 16'h0007});
    drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    #2;
    drive(1'b0, 1'b1, 16'h0100, 16'h0001);
    #1;
    check("between_edges", {1'b1, 1'b0, 16'h0007});
    drive(1'b0, 1'b0, 16'hAAAA, 16'h5555);
    tick();
    check("hold_after_glitch", {1'b0, 1'b0, 16'h0007});

    // Randomized sweep: 1000 operand pairs, occasional idle or reset cycles.
    m_sum  = 16'h0007;
    m_cout = 1'b0;
    m_ov   = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      logic         r;
      logic         v;
      logic [W-1:0] a;
      logic [W-1:0] b;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) != 0);
      a = W'($urandom_range(0, 65535));
      b = W'($urandom_range(0, 65535));
      if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
      drive(r, v, a, b);
      model_edge(r, v, a, b);
      exp_q.push_back({m_ov, m_cout, m_sum});
      tick();
      check("rand", exp_q.pop_front());
    end

    // No unknowns on the outputs after all that activity.
    n_tests++;
    if ($isunknown({bus.out_valid, bus.cout, bus.sum})) begin
      n_failed++;
      $display("FAIL x_safety: got %b expected no X/Z",
               {bus.out_valid, bus.cout, bus.sum});
    end

    drive(1'b0, 1'b0, '0, '0);
    tick();

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule : tb_adder_sixteen_bit

// File: doc/adder_sixteen_bit.md
Name: adder_sixteen_bit

Overview:
- Registered 16-bit unsigned adder used in the 8x8 sequential multiplier datapath, where it accumulates shifted partial products.
- Adds dataa and datab through a ripple-carry chain of 4-bit adder slices.
- Captures sum and carry-out in output registers on the rising clock edge.
- One-cycle latency with a simple valid qualifier.

Parameters:
- WIDTH, 16: operand and sum width; must be a multiple of 4. The default is the only configuration required in the multiplier.
- SLICE, 4: bits per ripple slice. Fixed; not meant to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle; a sum is captured only when high.
- dataa  input  WIDTH  unsigned operand A.
- datab  input  WIDTH  unsigned operand B.
- sum  output  WIDTH  registered sum bits [WIDTH-1:0].
- cout  output  1  registered carry-out (bit WIDTH of the full sum).
- out_valid  output  1  high for exactly one cycle, the cycle after in_valid was sampled high.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset). All state changes occur on the rising edge of clk.
- Reset: when reset=1 at a rising edge, sum<=0, cout<=0, out_valid<=0. Reset has priority over in_valid.
- Reset mid-operation: any operation sampled in the same cycle as reset is discarded, and no out_valid pulse follows it.
- Arithmetic: {cout,sum} = dataa + datab, computed at full WIDTH+1 precision. Unsigned only; no carry-in. Overflow shows up only in cout, and sum wraps modulo 2^WIDTH.
- Combinational path: WIDTH/SLICE slices in ripple order. Slice k takes bits [4k+3:4k] and the carry from slice k-1; slice 0 has carry-in 0. The final slice's carry is cout.
- Capture: at a rising edge with reset=0 and in_valid=1, the combinational result is registered into sum/cout and out_valid<=1.
- Idle: at a rising edge with reset=0 and in_valid=0, sum and cout hold their previous values and out_valid<=0.
- Latency and throughput: exactly 1 cycle from in_valid sampled to out_valid asserted, with results valid at that same time. Back-to-back in_valid is supported at one result per cycle. No stall or ready signal exists.
- Inputs are sampled only at clock edges. Input changes between edges have no effect on the outputs.
- X-safety: outputs are never X after the first reset edge, regardless of input activity.

Decomposition:
- Shared package: WIDTH default (16) and SLICE (4) as localparams.
- Sub-module: adder_four_bit, a combinational 4-bit ripple adder. Ports: a[3:0], b[3:0], cin, s[3:0], co.
- Top-level contents: generate-loop instantiation of adder_four_bit, the carry chain, and the output/valid registers.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1, dataa=0xFFFF, datab=1 -> sum=0, cout=0, out_valid=0 throughout.
- Small operands: dataa=10, datab=6, in_valid=1 -> next cycle sum=16, cout=0, out_valid=1.
- Back-to-back: 2+4 then 500+256 on consecutive cycles -> sum=6 then sum=756, cout=0, out_valid high both cycles.
- Overflow and hold: 0xFFFF+0x0001 -> sum=0x0000, cout=1. Then 0x8000+0x8000 -> sum=0, cout=1. Then in_valid=0 -> sum/cout hold, out_valid=0.
- Carry chain: 0x0FFF+0x0001 -> sum=0x1000, cout=0. The carry ripples across all slice boundaries.
- Reset mid-operation: in_valid=1 with 0x1234+0x1111 in the same cycle reset=1 -> next cycle sum=0, cout=0, out_valid=0. Then a random sweep of 1000 pairs, each checked against a WIDTH+1-bit reference model.
